// File: rtl/e_pkg.sv
// Shared types and constants for the e_rr_arb round-robin arbiter.
package e_pkg;

    // Arbiter FSM: IDLE re-arbitrates every cycle, LOCK holds the packet owner.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } e_rr_state_t;

    // Width of the completed-packet counter.
    localparam int unsigned E_RR_CNT_W = 16;

endpackage

// File: rtl/e_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
// Rotates a doubled request vector so the search always starts at bit 0,
// finds the first set bit, then maps the offset back to an absolute index.
module e_rr_pick #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    // One extra bit so start+offset (at most 2N-2) never overflows before the mod-N fold.
    localparam int unsigned SW = IDW + 1;

    logic [SW-1:0]  start;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;
    logic [SW-1:0]  sum;
    logic           found;

    // Rotate, find first set, un-rotate; ptr itself is searched last.
    always_comb begin
        if (ptr == IDW'(N - 1)) begin
            start = '0;
        end else begin
            start = SW'(ptr) + SW'(1);
        end
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = SW'(k);
            end
        end
        sum = start + off;
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        any    = found;
        idx    = found ? sum[IDW-1:0] : ptr;
        onehot = found ? (N'(1) << sum[IDW-1:0]) : '0;
    end

endmodule

// File: rtl/e_rr_arb.sv
// Round-robin packet arbiter with per-packet grant locking.
// Optional completed-packet counter is built when E_RR_ARB_CNT_EN is defined;
// otherwise gnt_cnt_o is tied to zero and no counter flops exist.
module e_rr_arb
    import e_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [N-1:0]          req_vld_i,
    input  logic [N-1:0]          req_last_i,
    output logic [N-1:0]          req_rdy_o,
    output logic                  gnt_vld_o,
    output logic [IDW-1:0]        gnt_id_o,
    output logic                  gnt_last_o,
    input  logic                  gnt_rdy_i,
    output logic [E_RR_CNT_W-1:0] gnt_cnt_o
);

    e_rr_state_t    state_r;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] own_r;

    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;

    logic [N-1:0]   sel_oh;
    logic [IDW-1:0] sel;
    logic           xfer;

    e_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req_vld_i),
        .ptr    (ptr_r),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Select the owner while locked, otherwise the round-robin winner; drive handshakes.
    always_comb begin
        if (state_r == LOCK) begin
            sel_oh    = N'(1) << own_r;
            sel       = own_r;
            gnt_vld_o = |(sel_oh & req_vld_i);
        end else begin
            sel_oh    = pick_oh;
            sel       = pick_idx;
            gnt_vld_o = pick_any;
        end
        gnt_id_o   = sel;
        gnt_last_o = gnt_vld_o & (|(sel_oh & req_last_i));
        xfer       = gnt_vld_o & gnt_rdy_i;
        req_rdy_o  = sel_oh & {N{xfer}};
    end

    // Packet FSM: pointer advances on last beat, owner locks on a non-last first beat.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= IDLE;
            ptr_r   <= IDW'(N - 1);
            own_r   <= '0;
        end else if (xfer) begin
            case (state_r)
                IDLE: begin
                    if (gnt_last_o) begin
                        ptr_r <= sel;
                    end else begin
                        own_r   <= sel;
                        state_r <= LOCK;
                    end
                end
                LOCK: begin
                    if (gnt_last_o) begin
                        ptr_r   <= own_r;
                        state_r <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef E_RR_ARB_CNT_EN
    logic [E_RR_CNT_W-1:0] cnt_r;

    // Saturating count of completed packets.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_r <= '0;
        end else if (xfer && gnt_last_o && (cnt_r != '1)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign gnt_cnt_o = cnt_r;
`else
    assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_e_rr_arb.sv
// Scoreboard bench for e_rr_arb with N=4 and directed vectors.
module tb_e_rr_arb;

    localparam int unsigned N = 4;

    logic         clk;
    logic         arst;
    logic [3:0]   req_vld_i;
    logic [3:0]   req_last_i;
    logic [3:0]   req_rdy_o;
    logic         gnt_vld_o;
    logic [1:0]   gnt_id_o;
    logic         gnt_last_o;
    logic         gnt_rdy_i;
    logic [15:0]  gnt_cnt_o;

    typedef struct packed {
        logic        vld;
        logic [1:0]  id;
        logic        last;
        logic [3:0]  rdy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mcnt = 16'h0;
    bit          stim_done = 1'b0;

    e_rr_arb #(
        .N (N)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_vld_i  (req_vld_i),
        .req_last_i (req_last_i),
        .req_rdy_o  (req_rdy_o),
        .gnt_vld_o  (gnt_vld_o),
        .gnt_id_o   (gnt_id_o),
        .gnt_last_o (gnt_last_o),
        .gnt_rdy_i  (gnt_rdy_i),
        .gnt_cnt_o  (gnt_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop the expectation issued this cycle and compare on the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check("gnt_vld", 16'(gnt_vld_o), 16'(e.vld));
            check("gnt_id", 16'(gnt_id_o), 16'(e.id));
            check("gnt_last", 16'(gnt_last_o), 16'(e.last));
            check("req_rdy", 16'(req_rdy_o), 16'(e.rdy));
            check("gnt_cnt", gnt_cnt_o, e.cnt);
        end
    end

    // Drive one cycle of inputs, queue the hand-computed response, advance a cycle.
    task automatic step(input logic a, input logic [3:0] v, input logic [3:0] l, input logic r,
                        input logic ev, input logic [1:0] eid, input logic el, input logic [3:0] erdy);
        exp_t e;
        arst       = a;
        req_vld_i  = v;
        req_last_i = l;
        gnt_rdy_i  = r;
        if (a) mcnt = 16'h0;
        e.vld  = ev;
        e.id   = eid;
        e.last = el;
        e.rdy  = erdy;
`ifdef E_RR_ARB_CNT_EN
        e.cnt  = mcnt;
`else
        e.cnt  = 16'h0;
`endif
        expq.push_back(e);
        if (!a && ev && r && el && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'h1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst       = 1'b1;
        req_vld_i  = '0;
        req_last_i = '0;
        gnt_rdy_i  = 1'b1;
        @(posedge clk);
        #1;
        // Reset state: no requests, id shows ptr=N-1.
        step(1, 4'b0000, 4'b0000, 1, 0, 2'd3, 0, 4'b0000);
        // Full rotation of single-beat packets from reset.
        step(0, 4'b1111, 4'b1111, 1, 1, 2'd0, 1, 4'b0001);
        step(0, 4'b1111, 4'b1111, 1, 1, 2'd1, 1, 4'b0010);
        step(0, 4'b1111, 4'b1111, 1, 1, 2'd2, 1, 4'b0100);
        step(0, 4'b1111, 4'b1111, 1, 1, 2'd3, 1, 4'b1000);
        step(0, 4'b1111, 4'b1111, 1, 1, 2'd0, 1, 4'b0001);
        // Move ptr to 2, then wrap-around to 0 then 1.
        step(0, 4'b0100, 4'b0100, 1, 1, 2'd2, 1, 4'b0100);
        step(0, 4'b0011, 4'b0011, 1, 1, 2'd0, 1, 4'b0001);
        step(0, 4'b0011, 4'b0011, 1, 1, 2'd1, 1, 4'b0010);
        // Lone requester re-granted after its own completion.
        step(0, 4'b0100, 4'b0100, 1, 1, 2'd2, 1, 4'b0100);
        step(0, 4'b0100, 4'b0100, 1, 1, 2'd2, 1, 4'b0100);
        // Not sticky before transfer: higher-priority 3 overtakes 0 while stalled.
        step(0, 4'b0001, 4'b0001, 0, 1, 2'd0, 1, 4'b0000);
        step(0, 4'b1001, 4'b1001, 0, 1, 2'd3, 1, 4'b0000);
        step(0, 4'b1001, 4'b1001, 1, 1, 2'd3, 1, 4'b1000);
        // 3-beat packet from 1 while 3 (and briefly 0) wait.
        step(0, 4'b1010, 4'b0000, 1, 1, 2'd1, 0, 4'b0010);
        step(0, 4'b1011, 4'b0000, 1, 1, 2'd1, 0, 4'b0010);
        step(0, 4'b1010, 4'b0010, 1, 1, 2'd1, 1, 4'b0010);
        step(0, 4'b1000, 4'b1000, 1, 1, 2'd3, 1, 4'b1000);
        // Owner 2 drops valid for two cycles mid-packet.
        step(0, 4'b0100, 4'b0000, 1, 1, 2'd2, 0, 4'b0100);
        $display("note: requester 2 deasserts valid mid-packet (protocol violation)");
        step(0, 4'b0001, 4'b0001, 1, 0, 2'd2, 0, 4'b0000);
        step(0, 4'b0001, 4'b0001, 1, 0, 2'd2, 0, 4'b0000);
        step(0, 4'b0101, 4'b0100, 1, 1, 2'd2, 1, 4'b0100);
        // Reset pulse while locked to owner 2.
        step(0, 4'b0100, 4'b0000, 1, 1, 2'd2, 0, 4'b0100);
        step(1, 4'b0101, 4'b0101, 1, 1, 2'd0, 1, 4'b0001);
        step(0, 4'b0101, 4'b0101, 1, 1, 2'd0, 1, 4'b0001);
        // Five completed packets, including a 2-beat one with a non-last beat.
        step(0, 4'b0101, 4'b0101, 1, 1, 2'd2, 1, 4'b0100);
        step(0, 4'b0101, 4'b0001, 1, 1, 2'd0, 1, 4'b0001);
        step(0, 4'b0110, 4'b0000, 1, 1, 2'd1, 0, 4'b0010);
        step(0, 4'b0110, 4'b0010, 1, 1, 2'd1, 1, 4'b0010);
        step(0, 4'b0110, 4'b0110, 1, 1, 2'd2, 1, 4'b0100);
        step(0, 4'b0000, 4'b0000, 1, 0, 2'd2, 0, 4'b0000);
`ifdef E_RR_ARB_CNT_EN
        // Saturation: counter preloaded to all ones must hold on another last beat.
        force dut.cnt_r = 16'hFFFF;
        mcnt = 16'hFFFF;
        step(0, 4'b0000, 4'b0000, 1, 0, 2'd2, 0, 4'b0000);
        release dut.cnt_r;
        step(0, 4'b1000, 4'b1000, 1, 1, 2'd3, 1, 4'b1000);
        step(0, 4'b0000, 4'b0000, 1, 0, 2'd3, 0, 4'b0000);
`endif
        stim_done = 1'b1;
    end

    // Bounded drain, then the summary.
    initial begin
        int cyc;
        cyc = 0;
        while (!(stim_done && expq.size() == 0) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 2000) begin
            n_errors++;
            $display("FAIL timeout: pending %0d expectations, required 0", expq.size());
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
